// File: rtl/elevator_controller.sv
// ---------------------------------------------------------------------------
// elevator_controller
//
// Purpose: collective controller for a four-floor car. Calls are latched into
// req_latch and serviced in the current travel direction; the car only
// reverses after passing through IDLE. The door dwells for DOOR_CYCLES cycles
// and can be held open or closed early from inside the car. Emergency stop
// parks the car with motors off and door shut while keeping pending calls.
//
// Ports:
//   clk            in   system clock, all state changes on the rising edge
//   reset          in   asynchronous reset, active low
//   request[3:0]   in   floor call buttons, bit i = floor i (pulses allowed)
//   floor_sensor   in   one-hot car position, bit i = car at floor i
//   door_open_btn  in   in-car door-open button
//   door_close_btn in   in-car door-close button
//   emergency_stop in   level-sensitive emergency stop
//   current_floor  out  binary index of the last valid (one-hot) sensor value
//   motor_up       out  hoist drive up
//   motor_down     out  hoist drive down
//   door_open      out  door actuator, 1 = open
//   emergency_led  out  1 while in the emergency state
//   dbg_state      out  raw FSM state for observation
//
// All outputs are flops: the actuator outputs are loaded from the decoded
// next state, so they always match the state register (Moore behaviour) and
// there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module elevator_controller #(
  parameter int unsigned DOOR_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] request,
  input  logic [3:0] floor_sensor,
  input  logic       door_open_btn,
  input  logic       door_close_btn,
  input  logic       emergency_stop,
  output logic [1:0] current_floor,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic       emergency_led,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_DOOR_OPEN = 3'd3,
    ST_EMERGENCY = 3'd4
  } state_t;

  localparam logic [7:0] DWELL_LOAD = 8'(DOOR_CYCLES);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] req_latch;
  logic [7:0] r_dwell;
  logic [7:0] w_dwell_next;
  logic [3:0] w_clear_mask;
  logic [3:0] w_req_new;
  logic [3:0] w_cur_onehot;
  logic [3:0] w_above_mask;
  logic [3:0] w_below_mask;
  logic       w_call_here;
  logic       w_call_above;
  logic       w_call_below;
  logic       w_sensor_valid;
  logic [1:0] w_sensor_idx;

  // Floor masks relative to the last sensed floor. Shifting out of the
  // 4-bit vector naturally gives an empty mask at the top/bottom floor.
  assign w_cur_onehot = 4'b0001 << current_floor;
  assign w_above_mask = 4'b1110 << current_floor;
  assign w_below_mask = ~(4'b1111 << current_floor);

  assign w_call_here  = |(req_latch & w_cur_onehot);
  assign w_call_above = |(req_latch & w_above_mask);
  assign w_call_below = |(req_latch & w_below_mask);

  // Sensor decode: only a clean one-hot pattern moves current_floor; a car
  // between floors (0000) or a faulty multi-bit reading keeps the old value.
  always_comb begin
    w_sensor_valid = 1'b1;
    w_sensor_idx   = 2'd0;
    case (floor_sensor)
      4'b0001: w_sensor_idx = 2'd0;
      4'b0010: w_sensor_idx = 2'd1;
      4'b0100: w_sensor_idx = 2'd2;
      4'b1000: w_sensor_idx = 2'd3;
      default: w_sensor_valid = 1'b0;
    endcase
  end

  // Calls are accepted only outside emergency (including the cycle in which
  // the stop is first seen). While the door is already open at this floor a
  // call for this floor is absorbed by the dwell reload instead of latched.
  always_comb begin
    w_req_new = '0;
    if ((r_state != ST_EMERGENCY) && !emergency_stop) begin
      w_req_new = request;
      if (r_state == ST_DOOR_OPEN) begin
        w_req_new = request & ~w_cur_onehot;
      end
    end
  end

  // Next state. Priority: emergency, then service at the current floor,
  // then travel.
  always_comb begin
    w_next_state = r_state;
    w_dwell_next = r_dwell;
    w_clear_mask = '0;
    if (emergency_stop) begin
      w_next_state = ST_EMERGENCY;
      w_dwell_next = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_call_here || door_open_btn) begin
            w_next_state = ST_DOOR_OPEN;
            w_clear_mask = w_cur_onehot;
            w_dwell_next = DWELL_LOAD;
          end else if (w_call_above) begin
            w_next_state = ST_MOVE_UP;
          end else if (w_call_below) begin
            w_next_state = ST_MOVE_DOWN;
          end
        end
        // While travelling the current-floor bit is tested first, so the
        // "at or above / at or below" test reduces to the strict masks.
        ST_MOVE_UP: begin
          if (w_call_here) begin
            w_next_state = ST_DOOR_OPEN;
            w_clear_mask = w_cur_onehot;
            w_dwell_next = DWELL_LOAD;
          end else if (!w_call_above) begin
            w_next_state = ST_IDLE;
          end
        end
        ST_MOVE_DOWN: begin
          if (w_call_here) begin
            w_next_state = ST_DOOR_OPEN;
            w_clear_mask = w_cur_onehot;
            w_dwell_next = DWELL_LOAD;
          end else if (!w_call_below) begin
            w_next_state = ST_IDLE;
          end
        end
        ST_DOOR_OPEN: begin
          // Open button (or a fresh call here) beats the close button.
          if (door_open_btn || |(request & w_cur_onehot)) begin
            w_dwell_next = DWELL_LOAD;
          end else if (door_close_btn || (r_dwell <= 8'd1)) begin
            w_next_state = ST_IDLE;
            w_dwell_next = '0;
          end else begin
            w_dwell_next = r_dwell - 8'd1;
          end
        end
        ST_EMERGENCY: begin
          w_next_state = ST_IDLE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_dwell <= '0;
    end else begin
      r_state <= w_next_state;
      r_dwell <= w_dwell_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_latch <= '0;
    end else begin
      req_latch <= (req_latch | w_req_new) & ~w_clear_mask;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      current_floor <= 2'd0;
    end else if (w_sensor_valid) begin
      current_floor <= w_sensor_idx;
    end
  end

  // Actuators are loaded from the decoded next state so they change on the
  // same edge as the state register; one state at a time keeps motor_up,
  // motor_down and door_open mutually exclusive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      motor_up      <= 1'b0;
      motor_down    <= 1'b0;
      door_open     <= 1'b0;
      emergency_led <= 1'b0;
    end else begin
      motor_up      <= (w_next_state == ST_MOVE_UP);
      motor_down    <= (w_next_state == ST_MOVE_DOWN);
      door_open     <= (w_next_state == ST_DOOR_OPEN);
      emergency_led <= (w_next_state == ST_EMERGENCY);
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_elevator_controller.sv
// ---------------------------------------------------------------------------
// tb_elevator_controller
//
// Directed scenarios followed by a randomized run. A behavioural model of the
// car (floor number, travel direction, door timer, emergency flag, pending
// call bits) predicts every output after every clock edge; a simple plant
// moves the floor sensor when the model says the car is travelling.
// ---------------------------------------------------------------------------
module tb_elevator_controller;

  localparam int DC = 5;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] request;
  logic [3:0] floor_sensor;
  logic       door_open_btn;
  logic       door_close_btn;
  logic       emergency_stop;
  logic [1:0] current_floor;
  logic       motor_up;
  logic       motor_down;
  logic       door_open;
  logic       emergency_led;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  elevator_controller #(.DOOR_CYCLES(DC)) dut (
    .clk            (clk),
    .reset          (reset),
    .request        (request),
    .floor_sensor   (floor_sensor),
    .door_open_btn  (door_open_btn),
    .door_close_btn (door_close_btn),
    .emergency_stop (emergency_stop),
    .current_floor  (current_floor),
    .motor_up       (motor_up),
    .motor_down     (motor_down),
    .door_open      (door_open),
    .emergency_led  (emergency_led),
    .dbg_state      (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- behavioural model ----------------
  int       m_floor;   // last valid floor number
  int       m_dir;     // +1 travelling up, -1 down, 0 not travelling
  int       m_door;    // cycles of door-open time left, 0 = closed
  bit       m_emerg;
  bit [3:0] m_pend;    // pending calls, one flag per floor

  // ---------------- plant ----------------
  bit auto_plant  = 1'b0;
  bit glitch_en   = 1'b0;
  int pos         = 0;
  int travel      = 0;
  int travel_time = 3;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_floor = 0;
    m_dir   = 0;
    m_door  = 0;
    m_emerg = 1'b0;
    m_pend  = 4'b0;
  endtask

  function automatic bit model_idle();
    return !m_emerg && (m_door == 0) && (m_dir == 0);
  endfunction

  // One clock edge of the car, from the inputs present before that edge.
  task automatic model_step(input logic [3:0] req, input logic [3:0] sens,
                            input bit ob, input bit cb, input bit es);
    int       f;
    bit       above;
    bit       below;
    bit       was_door;
    bit       accept;
    bit       clr;
    bit [3:0] newly;
    f = m_floor;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_pend[i] && (i > f)) above = 1'b1;
      if (m_pend[i] && (i < f)) below = 1'b1;
    end
    was_door = !m_emerg && (m_door > 0);
    accept   = !m_emerg && !es;
    clr      = 1'b0;
    if (es) begin
      m_emerg = 1'b1;
      m_dir   = 0;
      m_door  = 0;
    end else if (m_emerg) begin
      m_emerg = 1'b0;
    end else if (m_door > 0) begin
      if (ob || req[f]) m_door = DC;
      else if (cb || (m_door == 1)) m_door = 0;
      else m_door = m_door - 1;
    end else if (m_dir == 0) begin
      if (m_pend[f] || ob) begin
        m_door = DC;
        clr    = 1'b1;
      end else if (above) m_dir = 1;
      else if (below) m_dir = -1;
    end else begin
      if (m_pend[f]) begin
        m_dir  = 0;
        m_door = DC;
        clr    = 1'b1;
      end else if ((m_dir > 0) && !above) m_dir = 0;
      else if ((m_dir < 0) && !below) m_dir = 0;
    end
    newly = accept ? req : 4'b0;
    if (was_door) newly[f] = 1'b0;
    m_pend = m_pend | newly;
    if (clr) m_pend[f] = 1'b0;
    if ($countones(sens) == 1) begin
      for (int i = 0; i < 4; i++) if (sens[i]) m_floor = i;
    end
  endtask

  task automatic check_all();
    check("current_floor", 8'(current_floor), 8'(m_floor));
    check("motor_up", 8'(motor_up), 8'(!m_emerg && (m_door == 0) && (m_dir > 0)));
    check("motor_down", 8'(motor_down), 8'(!m_emerg && (m_door == 0) && (m_dir < 0)));
    check("door_open", 8'(door_open), 8'(m_door > 0));
    check("emergency_led", 8'(emergency_led), 8'(m_emerg));
    check("req_latch", 8'(dut.req_latch), 8'(m_pend));
  endtask

  // Car position follows the model's motor command; leaving a floor shows
  // an all-zero sensor for one cycle before the next floor is reached.
  task automatic plant_update();
    int dir;
    dir = (!m_emerg && (m_door == 0)) ? m_dir : 0;
    if ((dir != 0) && (pos + dir >= 0) && (pos + dir <= 3)) begin
      travel++;
      if (travel > travel_time) begin
        pos    = pos + dir;
        travel = 0;
      end
    end else begin
      travel = 0;
    end
    floor_sensor = (travel == travel_time) ? 4'b0 : 4'(1 << pos);
    if (glitch_en) floor_sensor = floor_sensor | 4'(1 << ((pos + 1) % 4));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [3:0] req, input bit ob, input bit cb, input bit es);
    @(negedge clk);
    if (auto_plant) plant_update();
    request        = req;
    door_open_btn  = ob;
    door_close_btn = cb;
    emergency_stop = es;
    model_step(req, floor_sensor, ob, cb, es);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int       cnt;
    int       downs;
    int       stops[$];
    bit       prev_door;
    int       es_left;
    logic [3:0] rq;
    bit       ob;
    bit       cb;
    bit       es;

    reset          = 1'b0;
    request        = 4'b0;
    floor_sensor   = 4'b0001;
    door_open_btn  = 1'b0;
    door_close_btn = 1'b0;
    emergency_stop = 1'b0;
    model_reset();

    // Reset state
    #2;
    check("rst_current_floor", 8'(current_floor), 8'd0);
    check("rst_motor_up", 8'(motor_up), 8'd0);
    check("rst_motor_down", 8'(motor_down), 8'd0);
    check("rst_door_open", 8'(door_open), 8'd0);
    check("rst_emergency_led", 8'(emergency_led), 8'd0);
    check("rst_req_latch", 8'(dut.req_latch), 8'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Single call to floor 3 from floor 0 with a hand-stepped sensor
    cycle(4'b1000, 0, 0, 0);
    check("s1_latched", 8'(dut.req_latch), 8'b1000);
    cycle(4'b0000, 0, 0, 0);
    check("s1_motor_up", 8'(motor_up), 8'd1);
    floor_sensor = 4'b0010;
    cycle(4'b0000, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0);
    check("s1_floor1", 8'(current_floor), 8'd1);
    floor_sensor = 4'b0100;
    cycle(4'b0000, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0);
    check("s1_floor2", 8'(current_floor), 8'd2);
    floor_sensor = 4'b1000;
    cycle(4'b0000, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0);
    check("s1_floor3", 8'(current_floor), 8'd3);
    check("s1_door_open", 8'(door_open), 8'd1);
    check("s1_motor_off", 8'(motor_up), 8'd0);
    check("s1_latch_clear", 8'(dut.req_latch), 8'd0);

    // Door hold and early close at floor 3
    cycle(4'b0000, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0);
    cycle(4'b0000, 1, 0, 0);
    cnt = door_open ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      cycle(4'b0000, 0, 0, 0);
      if (!door_open) break;
      cnt++;
    end
    check("s2_dwell_after_open_btn", 8'(cnt), 8'(DC));
    cycle(4'b0000, 1, 0, 0);
    check("s2_reopen", 8'(door_open), 8'd1);
    cycle(4'b0000, 0, 1, 0);
    check("s2_close_btn", 8'(door_open), 8'd0);

    // Emergency with a call pending below
    cycle(4'b0010, 0, 0, 0);
    check("s3_latched", 8'(dut.req_latch), 8'b0010);
    cycle(4'b0000, 0, 0, 1);
    cycle(4'b0100, 0, 0, 1);
    cycle(4'b0000, 0, 0, 1);
    check("s3_led", 8'(emergency_led), 8'd1);
    check("s3_motors_off", 8'({motor_up, motor_down}), 8'd0);
    check("s3_latch_kept", 8'(dut.req_latch), 8'b0010);
    cycle(4'b0000, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0);
    check("s3_motor_down", 8'(motor_down), 8'd1);
    check("s3_latch_after", 8'(dut.req_latch), 8'b0010);

    // Travel down to floor 1
    floor_sensor = 4'b0100;
    cycle(4'b0000, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0);
    check("s4_still_down", 8'(motor_down), 8'd1);
    floor_sensor = 4'b0010;
    cycle(4'b0000, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0);
    check("s4_door_open", 8'(door_open), 8'd1);
    check("s4_motor_off", 8'(motor_down), 8'd0);
    check("s4_latch_clear", 8'(dut.req_latch), 8'd0);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      cycle(4'b0000, 0, 0, 0);
      if (!door_open) break;
      cnt++;
    end
    check("s4_dwell", 8'(cnt), 8'(DC));

    // Back to floor 0 with the automatic plant
    auto_plant  = 1'b1;
    pos         = 1;
    travel      = 0;
    travel_time = 3;
    cycle(4'b0001, 0, 0, 0);
    for (int k = 0; k < 60; k++) begin
      cycle(4'b0000, 0, 0, 0);
      if (model_idle() && (m_pend == 4'b0) && (k > 2)) break;
    end
    check("s5_at_floor0", 8'(current_floor), 8'd0);

    // Calls for floors 1 and 2 collected while moving up
    cycle(4'b0100, 0, 0, 0);
    cycle(4'b0010, 0, 0, 0);
    downs     = 0;
    prev_door = door_open;
    for (int k = 0; k < 100; k++) begin
      cycle(4'b0000, 0, 0, 0);
      if (motor_down) downs++;
      if (door_open && !prev_door) stops.push_back(int'(current_floor));
      prev_door = door_open;
      if (model_idle() && (m_pend == 4'b0)) break;
    end
    check("s5_stop_count", 8'(stops.size()), 8'd2);
    if (stops.size() == 2) begin
      check("s5_first_stop", 8'(stops[0]), 8'd1);
      check("s5_second_stop", 8'(stops[1]), 8'd2);
    end
    check("s5_no_reverse", 8'(downs), 8'd0);

    // Asynchronous reset during upward travel
    cycle(4'b1000, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0);
    check("s6_moving", 8'(motor_up), 8'd1);
    #2;
    reset = 1'b0;
    #1;
    check("s6_motor_up", 8'(motor_up), 8'd0);
    check("s6_motor_down", 8'(motor_down), 8'd0);
    check("s6_door_open", 8'(door_open), 8'd0);
    check("s6_led", 8'(emergency_led), 8'd0);
    check("s6_latch", 8'(dut.req_latch), 8'd0);
    check("s6_floor", 8'(current_floor), 8'd0);
    model_reset();
    travel = 0;
    reset  = 1'b1;
    cycle(4'b0000, 0, 0, 0);
    check("s6_floor_follow", 8'(current_floor), 8'(pos));

    // Randomized traffic
    travel_time = $urandom_range(2, 4);
    es_left     = 0;
    for (int k = 0; k < 800; k++) begin
      rq = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      ob = ($urandom_range(0, 24) == 0);
      cb = ($urandom_range(0, 9) == 0);
      if ((es_left == 0) && ($urandom_range(0, 79) == 0)) es_left = $urandom_range(1, 5);
      es = (es_left > 0);
      if (es_left > 0) es_left--;
      glitch_en = ($urandom_range(0, 15) == 0);
      cycle(rq, ob, cb, es);
    end
    glitch_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
